// File: rtl/mips_cmp_pkg.sv
// Shared types and sizing helpers for the sequential SLT/SLTU comparator.
package mips_cmp_pkg;

  typedef enum logic [1:0] {
    CMP_IDLE,
    CMP_SCAN,
    CMP_DONE
  } cmp_state_t;

  localparam int CMP_WIDTH = 32;
  localparam int CMP_CHUNK = 8;

  function automatic int num_chunks(input int width, input int chunk);
    return width / chunk;
  endfunction

  // The chunk index needs at least one bit even when there is a single chunk.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int CMP_N     = num_chunks(CMP_WIDTH, CMP_CHUNK);
  localparam int CMP_IDX_W = idx_width(CMP_N);

endpackage

// File: rtl/cmp_chunk.sv
// Unsigned magnitude compare of one CHUNK-bit slice of the operands.
module cmp_chunk #(
  parameter int CHUNK = 8
) (
  input  logic [CHUNK-1:0] x,
  input  logic [CHUNK-1:0] y,
  output logic             x_lt,
  output logic             x_gt
);

  assign x_lt = (x < y);
  assign x_gt = (x > y);

endmodule

// File: rtl/seq_slt_comparator.sv
// Multi-cycle SLT/SLTU comparator: scans operands MSB chunk first and stops at
// the first differing chunk, presenting lt/eq/gt and a zero-extended SLT word.
module seq_slt_comparator
  import mips_cmp_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             is_signed,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             lt,
  output logic             eq,
  output logic             gt,
  output logic [WIDTH-1:0] slt_word
);

  localparam int N     = num_chunks(WIDTH, CHUNK);
  localparam int IDX_W = idx_width(N);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

  cmp_state_t       state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic             sgn_q, sgn_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             lt_q, lt_d, eq_q, eq_d, gt_q, gt_d;

  logic [CHUNK-1:0] x_chunk, y_chunk;
  logic             chunk_lt, chunk_gt;

  // Operands shift left each step, so the chunk under test is always the top
  // slice. Flipping the sign bit in chunk 0 turns a signed compare into an
  // unsigned one.
  always_comb begin
    x_chunk = a_q[WIDTH-1 -: CHUNK];
    y_chunk = b_q[WIDTH-1 -: CHUNK];
    if (sgn_q && (idx_q == '0)) begin
      x_chunk[CHUNK-1] = ~a_q[WIDTH-1];
      y_chunk[CHUNK-1] = ~b_q[WIDTH-1];
    end
  end

  cmp_chunk #(.CHUNK(CHUNK)) u_cmp_chunk (
    .x    (x_chunk),
    .y    (y_chunk),
    .x_lt (chunk_lt),
    .x_gt (chunk_gt)
  );

  // NOTE: every signal assigned here gets a hold value first, so no path
  // through the case leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sgn_d   = sgn_q;
    idx_d   = idx_q;
    lt_d    = lt_q;
    eq_d    = eq_q;
    gt_d    = gt_q;
    unique case (state_q)
      CMP_IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          sgn_d   = is_signed;
          idx_d   = '0;
          state_d = CMP_SCAN;
        end
      end
      CMP_SCAN: begin
        if (chunk_lt || chunk_gt) begin
          lt_d    = chunk_lt;
          gt_d    = chunk_gt;
          eq_d    = 1'b0;
          state_d = CMP_DONE;
        end else if (idx_q == LAST_IDX) begin
          lt_d    = 1'b0;
          gt_d    = 1'b0;
          eq_d    = 1'b1;
          state_d = CMP_DONE;
        end else begin
          idx_d = idx_q + IDX_W'(1);
          a_d   = a_q << CHUNK;
          b_d   = b_q << CHUNK;
        end
      end
      CMP_DONE: begin
        if (out_ready) begin
          lt_d    = 1'b0;
          eq_d    = 1'b0;
          gt_d    = 1'b0;
          state_d = CMP_IDLE;
        end
      end
      default: state_d = CMP_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge value of the others.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= CMP_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sgn_q   <= 1'b0;
      idx_q   <= '0;
      lt_q    <= 1'b0;
      eq_q    <= 1'b0;
      gt_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sgn_q   <= sgn_d;
      idx_q   <= idx_d;
      lt_q    <= lt_d;
      eq_q    <= eq_d;
      gt_q    <= gt_d;
    end
  end

  always_comb begin
    in_ready  = (state_q == CMP_IDLE);
    out_valid = (state_q == CMP_DONE);
    lt        = lt_q;
    eq        = eq_q;
    gt        = gt_q;
    slt_word  = {{(WIDTH-1){1'b0}}, lt_q};
  end

endmodule
